// File: rtl/i2c_result_tx_if.sv
// Purpose: carries the 128-bit AES result and its done level into the I2C read-path slave, and carries the status flags back out.
// Latency: plain wires with no storage.
// Backpressure: none; result_done is a level, and the slave acts on its rising edge.
// Ports (signals):
//   result      128-bit AES output. Byte 0 on the bus is result[127:120].
//   result_done level from the controller. Its rising edge captures result.
//   busy        read in progress. High from address match until STOP or NACK.
//   valid       the buffer holds a result that has not been fully read.
//   overrun     sticky. A pending result was overwritten before it was used.
//   bytes_sent  result bytes ACKed in the current read. Saturates at 16.
interface i2c_result_tx_if;
  logic [127:0] result;
  logic         result_done;
  logic         busy;
  logic         valid;
  logic         overrun;
  logic [4:0]   bytes_sent;

  modport master (output result, result_done, input busy, valid, overrun, bytes_sent);
  modport slave  (input result, result_done, output busy, valid, overrun, bytes_sent);
endinterface

// File: rtl/i2c_result_tx.sv
// Purpose: I2C slave read path. It latches the AES result and serves it as 16 bytes on a read at SLAVE_ADDR.
// Latency: responds 3 clocks after an scl/sda pin edge (2-flop synchroniser plus an edge stage), so clock must be at least 16x scl.
// Backpressure: the master paces everything through scl. The slave never stretches scl; it only pulls sda low or leaves it high-Z.
// Ports: clock, reset (async, active-low), scl (sampled only), sda (open-drain),
//        bus (slave modport: result/result_done in; busy/valid/overrun/bytes_sent out).
module i2c_result_tx #(
  parameter logic [6:0] SLAVE_ADDR = 7'h42,
  parameter int         NBYTES     = 16,
  parameter logic [7:0] FILL_BYTE  = 8'hFF
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           scl,
  inout  wire            sda,
  i2c_result_tx_if.slave bus
);

  localparam logic [4:0] NB = 5'(NBYTES);

  typedef enum logic [2:0] {S_IDLE, S_ADDR, S_ACK, S_ACK2, S_TX, S_RACK} state_t;

  state_t       state_q, state_d;
  logic [2:0]   scl_sync_q, scl_sync_d;
  logic [2:0]   sda_sync_q, sda_sync_d;
  logic [7:0]   shreg_q, shreg_d;
  logic [3:0]   bit_cnt_q, bit_cnt_d;
  logic [4:0]   byte_idx_q, byte_idx_d;
  logic         sda_oe_q, sda_oe_d;
  logic         busy_q, busy_d;
  logic [4:0]   bytes_sent_q, bytes_sent_d;
  logic [127:0] buf_q, buf_d;
  logic [127:0] pend_buf_q, pend_buf_d;
  logic         pend_q, pend_d;
  logic         valid_q, valid_d;
  logic         overrun_q, overrun_d;
  logic         done_q, done_d;

  logic         scl_rise, scl_fall, start_det, stop_det, sda_in;
  logic         busy_fall, done_rise;
  logic [127:0] buf_shift;
  logic [7:0]   cur_byte;

  // Stage 2 of each synchroniser is the current value; stage 3 is the previous value.
  assign sda_in    = sda_sync_q[1];
  assign scl_rise  = scl_sync_q[1] & ~scl_sync_q[2];
  assign scl_fall  = ~scl_sync_q[1] & scl_sync_q[2];
  assign start_det = scl_sync_q[1] & scl_sync_q[2] & sda_sync_q[2] & ~sda_sync_q[1];
  assign stop_det  = scl_sync_q[1] & scl_sync_q[2] & ~sda_sync_q[2] & sda_sync_q[1];

  assign sda = sda_oe_q ? 1'b0 : 1'bz;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= S_IDLE;
      scl_sync_q   <= 3'b111;   // idle bus level, so no false edge leaving reset
      sda_sync_q   <= 3'b111;
      shreg_q      <= '0;
      bit_cnt_q    <= '0;
      byte_idx_q   <= '0;
      sda_oe_q     <= 1'b0;
      busy_q       <= 1'b0;
      bytes_sent_q <= '0;
      buf_q        <= '0;
      pend_buf_q   <= '0;
      pend_q       <= 1'b0;
      valid_q      <= 1'b0;
      overrun_q    <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      scl_sync_q   <= scl_sync_d;
      sda_sync_q   <= sda_sync_d;
      shreg_q      <= shreg_d;
      bit_cnt_q    <= bit_cnt_d;
      byte_idx_q   <= byte_idx_d;
      sda_oe_q     <= sda_oe_d;
      busy_q       <= busy_d;
      bytes_sent_q <= bytes_sent_d;
      buf_q        <= buf_d;
      pend_buf_q   <= pend_buf_d;
      pend_q       <= pend_d;
      valid_q      <= valid_d;
      overrun_q    <= overrun_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    scl_sync_d   = {scl_sync_q[1:0], scl};
    sda_sync_d   = {sda_sync_q[1:0], sda};
    state_d      = state_q;
    shreg_d      = shreg_q;
    bit_cnt_d    = bit_cnt_q;
    byte_idx_d   = byte_idx_q;
    sda_oe_d     = sda_oe_q;
    busy_d       = busy_q;
    bytes_sent_d = bytes_sent_q;
    buf_d        = buf_q;
    pend_buf_d   = pend_buf_q;
    pend_d       = pend_q;
    valid_d      = valid_q;
    overrun_d    = overrun_q;
    done_d       = bus.result_done;
    buf_shift    = buf_q << {byte_idx_q[3:0], 3'b000};
    cur_byte     = buf_shift[127:120];

    if (start_det) begin
      // A START (including a repeated START) restarts address reception. busy is held.
      state_d   = S_ADDR;
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
    end else if (stop_det) begin
      state_d  = S_IDLE;
      sda_oe_d = 1'b0;
      busy_d   = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: ;
        S_ADDR: if (scl_rise) begin
          shreg_d   = {shreg_q[6:0], sda_in};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == 4'd7) begin
            // shreg_q[6:0] holds the 7-bit address; sda_in is the R/W bit.
            if (shreg_q[6:0] == SLAVE_ADDR && sda_in && valid_q) state_d = S_ACK;
            else                                                 state_d = S_IDLE;
          end
        end
        S_ACK: if (scl_fall) begin
          sda_oe_d = 1'b1;
          state_d  = S_ACK2;
        end
        S_ACK2: if (scl_fall) begin
          // The falling edge that ends the ACK clock also launches bit 7 of byte 0.
          busy_d       = 1'b1;
          bytes_sent_d = '0;
          sda_oe_d     = ~buf_q[127];
          shreg_d      = {buf_q[126:120], 1'b0};
          bit_cnt_d    = 4'd1;
          byte_idx_d   = 5'd1;
          state_d      = S_TX;
        end
        S_TX: if (scl_fall) begin
          if (bit_cnt_q == 4'd8) begin
            sda_oe_d = 1'b0;
            state_d  = S_RACK;
          end else begin
            sda_oe_d  = ~shreg_q[7];
            shreg_d   = {shreg_q[6:0], 1'b0};
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_RACK: if (scl_rise) begin
          if (!sda_in) begin
            if (bytes_sent_q != NB) bytes_sent_d = bytes_sent_q + 5'd1;
            shreg_d   = (byte_idx_q >= NB) ? FILL_BYTE : cur_byte;
            if (byte_idx_q != NB) byte_idx_d = byte_idx_q + 5'd1;
            bit_cnt_d = '0;
            state_d   = S_TX;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // Result capture. The buffer only changes while no read is in progress.
    busy_fall = busy_q & ~busy_d;
    done_rise = bus.result_done & ~done_q;
    if (busy_fall) begin
      if (bytes_sent_q == NB) valid_d = 1'b0;
      if (pend_q) begin
        buf_d   = pend_buf_q;
        valid_d = 1'b1;
      end
      pend_d = 1'b0;
    end
    if (done_rise) begin
      if (!busy_q || busy_fall) begin
        // When busy falls on the same cycle, a fresh result beats any pending one.
        buf_d   = bus.result;
        valid_d = 1'b1;
      end else begin
        pend_buf_d = bus.result;
        pend_d     = 1'b1;
        if (pend_q) overrun_d = 1'b1;
      end
    end
  end

  always_comb begin
    bus.busy       = busy_q;
    bus.valid      = valid_q;
    bus.overrun    = overrun_q;
    bus.bytes_sent = bytes_sent_q;
  end

endmodule

// File: tb/tb_i2c_result_tx.sv
module tb_i2c_result_tx;
  localparam int Q = 80;  // quarter scl period: 8 system clocks

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic scl   = 1'b1;
  logic m_oe  = 1'b0;
  wire  sda;
  int   n_vec = 0;
  int   n_err = 0;

  logic [127:0] r1 = 128'h00112233_44556677_8899AABB_CCDDEEFF;
  logic [127:0] r2 = 128'h0F1E2D3C_4B5A6978_8796A5B4_C3D2E1F0;
  logic [127:0] r3 = 128'hA0A1A2A3_A4A5A6A7_A8A9AAAB_ACADAEAF;
  logic [127:0] r4 = 128'hB0B1B2B3_B4B5B6B7_B8B9BABB_BCBDBEBF;
  logic [127:0] r5 = 128'hC0C1C2C3_C4C5C6C7_C8C9CACB_CCCDCECF;

  pullup (sda);
  assign sda = m_oe ? 1'b0 : 1'bz;

  i2c_result_tx_if ifc();

  i2c_result_tx dut (
    .clock (clock),
    .reset (reset),
    .scl   (scl),
    .sda   (sda),
    .bus   (ifc)
  );

  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic done_pulse(input logic [127:0] v);
    ifc.result = v;
    ifc.result_done = 1'b1;
    #30;
    ifc.result_done = 1'b0;
    #30;
  endtask

  task automatic bus_start();
    if (scl == 1'b0) begin
      m_oe = 1'b0; #Q;
      scl = 1'b1;  #Q;
    end
    m_oe = 1'b1; #Q;
    scl = 1'b0;  #Q;
  endtask

  task automatic bus_stop();
    m_oe = 1'b1; #Q;
    scl = 1'b1;  #Q;
    m_oe = 1'b0; #Q;
  endtask

  task automatic bus_bit(input logic b, output logic r);
    m_oe = ~b; #Q;
    scl = 1'b1; #Q;
    r = sda; #Q;
    scl = 1'b0; #Q;
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic acked);
    logic r;
    for (int i = 7; i >= 0; i--) bus_bit(d[i], r);
    bus_bit(1'b1, r);
    acked = ~r;
  endtask

  task automatic rd_byte(input logic ack, output logic [7:0] d);
    logic r;
    for (int i = 7; i >= 0; i--) begin
      bus_bit(1'b1, r);
      d[i] = r;
    end
    bus_bit(~ack, r);
  endtask

  task automatic test_reset();
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", ifc.busy); end
    n_vec++; if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", ifc.valid); end
    n_vec++; if (ifc.overrun !== 1'b0) begin n_err++; $display("FAIL reset_overrun: got %b want 0", ifc.overrun); end
    n_vec++; if (ifc.bytes_sent !== 5'd0) begin n_err++; $display("FAIL reset_bytes_sent: got %0d want 0", ifc.bytes_sent); end
    n_vec++; if (sda !== 1'b1) begin n_err++; $display("FAIL reset_sda: got %b want 1", sda); end
  endtask

  task automatic test_no_result();
    logic ack;
    bus_start();
    wr_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL noresult_ack: got %b want 0", ack); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL noresult_busy: got %b want 0", ifc.busy); end
    bus_stop();
  endtask

  task automatic test_full_read();
    logic ack;
    logic [7:0] d;
    done_pulse(r1);
    n_vec++; if (ifc.valid !== 1'b1) begin n_err++; $display("FAIL full_valid_set: got %b want 1", ifc.valid); end
    bus_start();
    wr_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL full_addr_ack: got %b want 1", ack); end
    for (int i = 0; i < 16; i++) begin
      rd_byte(1'b1, d);
      n_vec++; if (d !== r1[127-8*i -: 8]) begin n_err++; $display("FAIL full_byte%0d: got %h want %h", i, d, r1[127-8*i -: 8]); end
    end
    n_vec++; if (ifc.bytes_sent !== 5'd16) begin n_err++; $display("FAIL full_bytes_sent: got %0d want 16", ifc.bytes_sent); end
    n_vec++; if (ifc.busy !== 1'b1) begin n_err++; $display("FAIL full_busy: got %b want 1", ifc.busy); end
    bus_stop();
    #Q;
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL full_busy_after_stop: got %b want 0", ifc.busy); end
    n_vec++; if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL full_valid_after_stop: got %b want 0", ifc.valid); end
  endtask

  task automatic test_nack_reread();
    logic ack;
    logic [7:0] d;
    done_pulse(r2);
    bus_start();
    wr_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL nack_addr_ack: got %b want 1", ack); end
    for (int i = 0; i < 4; i++) begin
      rd_byte(i < 3, d);
      n_vec++; if (d !== r2[127-8*i -: 8]) begin n_err++; $display("FAIL nack_byte%0d: got %h want %h", i, d, r2[127-8*i -: 8]); end
    end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL nack_busy: got %b want 0", ifc.busy); end
    n_vec++; if (ifc.bytes_sent !== 5'd3) begin n_err++; $display("FAIL nack_bytes_sent: got %0d want 3", ifc.bytes_sent); end
    bus_stop();
    n_vec++; if (ifc.valid !== 1'b1) begin n_err++; $display("FAIL nack_valid: got %b want 1", ifc.valid); end
    bus_start();
    wr_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL reread_addr_ack: got %b want 1", ack); end
    rd_byte(1'b0, d);
    n_vec++; if (d !== 8'h0F) begin n_err++; $display("FAIL reread_byte0: got %h want 0f", d); end
    bus_stop();
  endtask

  task automatic test_fill();
    logic ack;
    logic [7:0] d;
    logic [7:0] exp;
    bus_start();
    wr_byte(8'h85, ack);
    n_vec++; if (ack !== 1'b1) begin n_err++; $display("FAIL fill_addr_ack: got %b want 1", ack); end
    for (int i = 0; i < 18; i++) begin
      rd_byte(1'b1, d);
      exp = (i < 16) ? r2[127-8*i -: 8] : 8'hFF;
      n_vec++; if (d !== exp) begin n_err++; $display("FAIL fill_byte%0d: got %h want %h", i, d, exp); end
    end
    n_vec++; if (ifc.bytes_sent !== 5'd16) begin n_err++; $display("FAIL fill_bytes_sent: got %0d want 16", ifc.bytes_sent); end
    bus_stop();
    #Q;
    n_vec++; if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL fill_valid: got %b want 0", ifc.valid); end
  endtask

  task automatic test_overrun();
    logic ack;
    logic [7:0] d;
    done_pulse(r3);
    bus_start();
    wr_byte(8'h85, ack);
    rd_byte(1'b1, d);
    n_vec++; if (d !== 8'hA0) begin n_err++; $display("FAIL ovr_byte0: got %h want a0", d); end
    done_pulse(r4);
    n_vec++; if (ifc.overrun !== 1'b0) begin n_err++; $display("FAIL ovr_after_first: got %b want 0", ifc.overrun); end
    done_pulse(r5);
    n_vec++; if (ifc.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_after_second: got %b want 1", ifc.overrun); end
    rd_byte(1'b0, d);
    n_vec++; if (d !== 8'hA1) begin n_err++; $display("FAIL ovr_byte1: got %h want a1", d); end
    bus_stop();
    n_vec++; if (ifc.valid !== 1'b1) begin n_err++; $display("FAIL ovr_valid: got %b want 1", ifc.valid); end
    bus_start();
    wr_byte(8'h85, ack);
    rd_byte(1'b1, d);
    n_vec++; if (d !== 8'hC0) begin n_err++; $display("FAIL ovr_new_byte0: got %h want c0", d); end
    rd_byte(1'b0, d);
    n_vec++; if (d !== 8'hC1) begin n_err++; $display("FAIL ovr_new_byte1: got %h want c1", d); end
    bus_stop();
    n_vec++; if (ifc.overrun !== 1'b1) begin n_err++; $display("FAIL ovr_sticky: got %b want 1", ifc.overrun); end
  endtask

  task automatic test_reset_mid_tx();
    logic ack;
    done_pulse(r1);
    bus_start();
    wr_byte(8'h85, ack);
    m_oe = 1'b0; #Q;
    scl = 1'b1;  #Q;
    n_vec++; if (sda !== 1'b0) begin n_err++; $display("FAIL rst_tx_driving: got %b want 0", sda); end
    reset = 1'b0;
    #1;
    n_vec++; if (sda !== 1'b1) begin n_err++; $display("FAIL rst_sda_release: got %b want 1", sda); end
    n_vec++; if (ifc.busy !== 1'b0) begin n_err++; $display("FAIL rst_busy: got %b want 0", ifc.busy); end
    n_vec++; if (ifc.valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b want 0", ifc.valid); end
    n_vec++; if (ifc.overrun !== 1'b0) begin n_err++; $display("FAIL rst_overrun: got %b want 0", ifc.overrun); end
    n_vec++; if (ifc.bytes_sent !== 5'd0) begin n_err++; $display("FAIL rst_bytes_sent: got %0d want 0", ifc.bytes_sent); end
    #29;
    reset = 1'b1;
    #20;
    scl = 1'b0; #Q;
    bus_stop();
    bus_start();
    wr_byte(8'h84, ack);
    n_vec++; if (ack !== 1'b0) begin n_err++; $display("FAIL rst_write_ack: got %b want 0", ack); end
    bus_stop();
  endtask

  initial begin
    ifc.result = '0;
    ifc.result_done = 1'b0;
    #23;
    reset = 1'b1;
    #20;
    test_reset();
    test_no_result();
    test_full_read();
    test_nack_reread();
    test_fill();
    test_overrun();
    test_reset_mid_tx();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
